// File: rtl/pwm_latch_scheduler_if.sv
// Host/PWM-core side signals of the latch scheduler. The scheduler connects through the
// slave modport. The register block that drives it connects through the master modport.
interface pwm_latch_scheduler_if #(
    parameter int NB_PWM     = 24,
    parameter int RESOLUTION = 10,
    parameter int CHAN_W     = 5
);
    logic                  wr_en;
    logic [CHAN_W-1:0]     wr_chan;
    logic [RESOLUTION-1:0] wr_duty;
    logic                  oe_wr;
    logic [NB_PWM-1:0]     oe_data;
    logic [RESOLUTION-1:0] ton;
    logic [NB_PWM-1:0]     nlatch;
    logic [NB_PWM-1:0]     oe;
    logic                  busy;
    logic [NB_PWM-1:0]     pending;

    modport master (
        output wr_en, wr_chan, wr_duty, oe_wr, oe_data,
        input  ton, nlatch, oe, busy, pending
    );

    modport slave (
        input  wr_en, wr_chan, wr_duty, oe_wr, oe_data,
        output ton, nlatch, oe, busy, pending
    );
endinterface

// File: rtl/pwm_latch_scheduler.sv
// Round-robin loader for per-channel PWM duty values. It drives the shared Ton bus and
// pulses one active-low nlatch line per load. It also holds the output-enable register.
module pwm_latch_scheduler #(
    parameter int NB_PWM       = 24,
    parameter int RESOLUTION   = 10,
    parameter int CHAN_W       = 5,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pwm_latch_scheduler_if.slave bus
);
    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, LATCH, HOLD} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [RESOLUTION-1:0] shadow [NB_PWM];
    logic [CHAN_W-1:0]     ptr;
    logic [CHAN_W-1:0]     chan;
    logic [CHAN_W-1:0]     sel_chan;
    logic [CHAN_W-1:0]     idx;
    logic                  sel_valid;
    logic [RESOLUTION-1:0] sel_duty;
    logic [CNT_W-1:0]      cnt;
    logic [NB_PWM-1:0]     pending_nxt;
    logic                  wr_ok;

    assign wr_ok    = bus.wr_en && (int'(bus.wr_chan) < NB_PWM);
    assign bus.busy = (state != IDLE);

    // Walk the pending channels from ptr + NB_PWM - 1 back down to ptr.
    // The last hit is therefore the first pending channel at or after ptr, with wrap-around.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        int j;
        j         = 0;
        idx       = '0;
        sel_valid = 1'b0;
        sel_chan  = '0;
        for (int i = NB_PWM - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NB_PWM) j = j - NB_PWM;
            idx = CHAN_W'(j);
            if (bus.pending[idx]) begin
                sel_valid = 1'b1;
                sel_chan  = idx;
            end
        end
    end

    // A write to the channel being selected on this same edge is forwarded to ton.
    // Without forwarding, the newer duty would be dropped when pending clears after SETUP.
    assign sel_duty = (wr_ok && bus.wr_chan == sel_chan) ? bus.wr_duty : shadow[sel_chan];

    // Pending is cleared on the SETUP->LATCH edge. A write on that same edge sets it again.
    always_comb begin
        pending_nxt = bus.pending;
        if (state == SETUP) pending_nxt[chan] = 1'b0;
        if (wr_ok)          pending_nxt[bus.wr_chan] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_valid) state_nxt = SETUP;
            SETUP:   state_nxt = LATCH;
            LATCH:   if (cnt == '0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ton     <= '0;
            bus.nlatch  <= '1;
            bus.oe      <= '0;
            bus.pending <= '0;
            ptr         <= '0;
            chan        <= '0;
            cnt         <= '0;
            // NOTE: the shadow table is explicitly cleared, so a channel loaded before any write gets duty 0.
            for (int i = 0; i < NB_PWM; i++) shadow[i] <= '0;
        end else begin
            bus.pending <= pending_nxt;
            if (wr_ok)      shadow[bus.wr_chan] <= bus.wr_duty;
            if (bus.oe_wr)  bus.oe <= bus.oe_data;
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        chan    <= sel_chan;
                        bus.ton <= sel_duty;
                    end
                end
                SETUP: begin
                    bus.nlatch[chan] <= 1'b0;
                    cnt              <= CNT_W'(LATCH_CYCLES - 1);
                end
                LATCH: begin
                    if (cnt == '0) bus.nlatch <= '1;
                    else           cnt <= cnt - 1'b1;
                end
                HOLD: begin
                    ptr <= (int'(chan) == NB_PWM - 1) ? '0 : chan + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_latch_scheduler.sv
// Self-checking bench for pwm_latch_scheduler.
// A per-load step model drives directed scenarios plus a randomized soak, and every cycle is compared.
module tb_pwm_latch_scheduler;
    localparam int NB  = 24;
    localparam int RES = 10;
    localparam int CW  = 5;
    localparam int LC  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pwm_latch_scheduler_if #(.NB_PWM(NB), .RESOLUTION(RES), .CHAN_W(CW)) bus ();

    pwm_latch_scheduler #(
        .NB_PWM(NB), .RESOLUTION(RES), .CHAN_W(CW), .LATCH_CYCLES(LC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. A load is a sequence of LC+3 numbered steps, and step 0 means idle.
    logic [RES-1:0] m_shadow [NB];
    bit             m_pending [NB];
    logic [RES-1:0] m_ton;
    logic [NB-1:0]  m_oe;
    int             m_ptr, m_step, m_chan;

    // Pulse monitor results.
    int             pulse_chan [$];
    int             pulse_ton  [$];
    int             load_cnt   [NB];
    int             load_ton   [NB];
    logic [NB-1:0]  prev_nlatch = '1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int  ch;
        bit  wv;
        int  c_sel;
        ch = int'(bus.wr_chan);
        wv = bus.wr_en && ch < NB;
        if (reset) begin
            for (int k = 0; k < NB; k++) begin
                m_shadow[k]  = '0;
                m_pending[k] = 1'b0;
            end
            m_ton = '0; m_oe = '0; m_ptr = 0; m_step = 0; m_chan = 0;
            return;
        end
        c_sel = -1;
        if (m_step == 0) begin
            for (int k = 0; k < NB; k++) begin
                if (m_pending[(m_ptr + k) % NB]) begin
                    c_sel = (m_ptr + k) % NB;
                    break;
                end
            end
            if (c_sel >= 0) begin
                m_chan = c_sel;
                m_ton  = (wv && ch == c_sel) ? bus.wr_duty : m_shadow[c_sel];
                m_step = 1;
            end
        end else if (m_step == LC + 2) begin
            m_ptr  = (m_chan + 1) % NB;
            m_step = 0;
        end else begin
            if (m_step == 1) m_pending[m_chan] = 1'b0;
            m_step++;
        end
        if (wv) begin
            m_shadow[ch]  = bus.wr_duty;
            m_pending[ch] = 1'b1;
        end
        if (bus.oe_wr) m_oe = bus.oe_data;
    endtask

    task automatic compare_all();
        logic [NB-1:0] exp_nl;
        logic [NB-1:0] exp_p;
        exp_nl = '1;
        if (m_step >= 2 && m_step <= LC + 1) exp_nl[m_chan] = 1'b0;
        for (int k = 0; k < NB; k++) exp_p[k] = m_pending[k];
        check("ton",     32'(bus.ton),     32'(m_ton));
        check("nlatch",  32'(bus.nlatch),  32'(exp_nl));
        check("oe",      32'(bus.oe),      32'(m_oe));
        check("pending", 32'(bus.pending), 32'(exp_p));
        check("busy",    32'(bus.busy),    32'(m_step != 0));
        check("one_low_max", 32'($countones(~bus.nlatch) <= 1), 32'd1);
    endtask

    task automatic monitor();
        if (prev_nlatch == '1 && bus.nlatch != '1) begin
            for (int k = 0; k < NB; k++) begin
                if (!bus.nlatch[k]) begin
                    pulse_chan.push_back(k);
                    pulse_ton.push_back(int'(bus.ton));
                    load_cnt[k]++;
                    load_ton[k] = int'(bus.ton);
                end
            end
        end
        prev_nlatch = bus.nlatch;
    endtask

    task automatic step(input logic we, input int ch, input int duty,
                        input logic ow, input logic [NB-1:0] od, input logic rst);
        bus.wr_en   = we;
        bus.wr_chan = CW'(ch);
        bus.wr_duty = RES'(duty);
        bus.oe_wr   = ow;
        bus.oe_data = od;
        reset       = rst;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        monitor();
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic write(input int ch, input int duty);
        step(1'b1, ch, duty, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 5, 3, 1'b0, '0, 1'b1);
    endtask

    task automatic clear_log();
        pulse_chan.delete();
        pulse_ton.delete();
        for (int k = 0; k < NB; k++) begin
            load_cnt[k] = 0;
            load_ton[k] = -1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((bus.busy || bus.pending != '0) && n < budget) begin
            idle();
            n++;
        end
        check("idle_within_budget", 32'(!(bus.busy || bus.pending != '0)), 32'd1);
    endtask

    initial begin
        int exp_rr [5];
        int order  [NB];
        int duty   [NB];
        int tmp, r;

        // Reset held for two cycles while a write is offered.
        do_reset();
        do_reset();
        check("rst_ton",     32'(bus.ton),     32'h0);
        check("rst_nlatch",  32'(bus.nlatch),  32'hFFFFFF);
        check("rst_oe",      32'(bus.oe),      32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        clear_log();

        // Single load of chan 5, with its latency checked explicitly.
        write(5, 'h155);
        idle(); check("single_ton_e1",    32'(bus.ton),     32'h155);
                check("single_nl_e1",     32'(bus.nlatch),  32'hFFFFFF);
        idle(); check("single_nl_e2",     32'(bus.nlatch),  32'hFFFFDF);
                check("single_pend_e2",   32'(bus.pending), 32'h0);
        idle(); check("single_nl_e3",     32'(bus.nlatch),  32'hFFFFDF);
        idle(); check("single_nl_e4",     32'(bus.nlatch),  32'hFFFFFF);
                check("single_busy_e4",   32'(bus.busy),    32'h1);
        idle(); check("single_busy_e5",   32'(bus.busy),    32'h0);
        check("single_pulses", 32'(pulse_chan.size()), 32'd1);

        // Round robin: chan 23 keeps the FSM busy while 3, 20 and 1 arrive, and ptr then wraps to 0.
        do_reset();
        clear_log();
        write(23, 'h017);
        write(3, 'h003);
        write(20, 'h020);
        write(1, 'h001);
        wait_idle(100);
        write(0, 'h2AA);
        wait_idle(100);
        exp_rr = '{23, 1, 3, 20, 0};
        check("rr_count", 32'(pulse_chan.size()), 32'd5);
        for (int k = 0; k < 5 && k < pulse_chan.size(); k++)
            check("rr_order", 32'(pulse_chan[k]), 32'(exp_rr[k]));

        // Collision: chan 7 is rewritten while its latch pulse is low.
        clear_log();
        write(7, 100);
        idle();
        idle();
        check("coll_in_latch", 32'(bus.nlatch), 32'hFFFF7F);
        write(7, 200);
        wait_idle(100);
        check("coll_count", 32'(pulse_chan.size()), 32'd2);
        if (pulse_chan.size() == 2) begin
            check("coll_ton0", 32'(pulse_ton[0]), 32'd100);
            check("coll_ton1", 32'(pulse_ton[1]), 32'd200);
        end
        check("coll_pending", 32'(bus.pending), 32'h0);

        // An out-of-range channel write is ignored. The OE write is then checked idle and busy.
        clear_log();
        write(24, 'h3FF);
        check("oob_pending", 32'(bus.pending), 32'h0);
        idle();
        check("oob_busy", 32'(bus.busy), 32'h0);
        check("oob_pulses", 32'(pulse_chan.size()), 32'd0);
        step(1'b0, 0, 0, 1'b1, 24'hA5A5A5, 1'b0);
        check("oe_idle", 32'(bus.oe), 32'hA5A5A5);
        write(2, 'h0F0);
        idle();
        step(1'b0, 0, 0, 1'b1, 24'h5A5A5A, 1'b0);
        check("oe_busy_flag", 32'(bus.busy), 32'h1);
        check("oe_busy",      32'(bus.oe),   32'h5A5A5A);
        wait_idle(100);

        // A reset in the middle of a load aborts it.
        write(9, 'h099);
        idle();
        idle();
        write(4, 'h044);
        do_reset();
        check("abort_nlatch",  32'(bus.nlatch),  32'hFFFFFF);
        check("abort_pending", 32'(bus.pending), 32'h0);
        check("abort_busy",    32'(bus.busy),    32'h0);
        idle();
        check("abort_after", 32'(bus.nlatch), 32'hFFFFFF);

        // All channels are written once, in shuffled order with random duties.
        clear_log();
        for (int k = 0; k < NB; k++) begin
            order[k] = k;
            duty[k]  = int'($urandom_range(0, (1 << RES) - 1));
        end
        for (int k = NB - 1; k > 0; k--) begin
            r = int'($urandom_range(0, k));
            tmp = order[k]; order[k] = order[r]; order[r] = tmp;
        end
        for (int k = 0; k < NB; k++) write(order[k], duty[order[k]]);
        wait_idle(NB * (LC + 3) + 20);
        for (int k = 0; k < NB; k++) begin
            check("all_load_cnt", 32'(load_cnt[k]), 32'd1);
            check("all_load_ton", 32'(load_ton[k]), 32'(duty[k]));
        end

        // Randomized soak against the model, including invalid channels and rare resets.
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 31)),
                 int'($urandom_range(0, (1 << RES) - 1)),
                 1'($urandom_range(0, 7) == 0),
                 NB'($urandom),
                 1'($urandom_range(0, 199) == 0));
        end
        wait_idle(NB * (LC + 3) + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
